// File: rtl/ram_master_pkg.sv
// Shared constants and FSM encoding for the RAM initiator and its neighbours.
package ram_master_pkg;

  localparam int ADDR_W    = 8;    // request / RAM address width
  localparam int DATA_W    = 8;    // data width
  localparam int MEM_DEPTH = 128;  // valid words; addresses >= MEM_DEPTH are illegal
  localparam int LEN_W     = 4;    // burst length field; beats = len + 1

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_master.sv
// Burst read/write initiator for the single-port RAM. Write data passes
// straight through to the RAM; read data lands in a one-deep output register
// so the consumer can stall without losing or repeating a beat.
module ram_master
  import ram_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                err_q, err_d;

  // Last address of the burst, one bit wider so it cannot wrap past the top.
  logic [ADDR_W:0]     end_addr;
  logic                range_bad;
  logic                rd_issue;
  logic                wr_beat;

  // Range check and per-cycle RAM access decisions.
  always_comb begin
    end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
    range_bad = (end_addr >= (ADDR_W+1)'(MEM_DEPTH));
    // A read beat may only be issued when the output register is empty or
    // is being emptied this very cycle.
    rd_issue  = (state_q == ST_READ) && (!rvalid_q || rdata_ready);
    wr_beat   = (state_q == ST_WRITE) && wdata_valid;
  end

  // Next-state, address/count stepping and read output register.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    err_d    = 1'b0;

    if (rvalid_q && rdata_ready) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            cnt_d   = req_len;
            state_d = req_write ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          rdata_d  = mem_rdata;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == '0);
          addr_d   = addr_q + ADDR_W'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        if (wr_beat) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (rvalid_q && rdata_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      err_q    <= err_d;
    end
  end

  // Output decode; write data is gated so the RAM bus idles at zero.
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    wdata_ready = (state_q == ST_WRITE);
    mem_wr_en   = wr_beat;
    mem_rd_en   = rd_issue;
    mem_addr    = addr_q;
    mem_wdata   = (state_q == ST_WRITE) ? wdata : '0;
    rdata       = rdata_q;
    rdata_valid = rvalid_q;
    rdata_last  = rlast_q;
    done        = (state_q == ST_DONE);
    err         = err_q;
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural 128 x 8 RAM attached.
module tb_ram_master;
  import ram_master_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;

  ram_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on the rising edge.
  logic [7:0] ram [128];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'(i);
    end else if (mem_wr_en) begin
      ram[mem_addr[6:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr[6:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor sampling just before each rising edge.
  int         rd_cnt = 0, wr_cnt = 0, both_err = 0, lat_err = 0, stab_err = 0;
  int         done_cnt = 0, err_cnt = 0;
  logic       prev_stall = 1'b0, prev_rd = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] beat_q[$];
  logic       last_q[$];

  always begin
    @(negedge clk);
    #4;
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en && mem_wr_en) both_err++;
    if (prev_rd && !rdata_valid) lat_err++;
    if (prev_stall && rdata_valid && (rdata !== prev_data)) stab_err++;
    if (rdata_valid && rdata_ready) begin
      beat_q.push_back(rdata);
      last_q.push_back(rdata_last);
    end
    prev_stall = rdata_valid && !rdata_ready;
    prev_data  = rdata;
    prev_rd    = mem_rd_en;
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  logic [7:0] exp_data [16];
  logic [7:0] wr_data  [16];

  // Read burst; expected beats come from exp_data[0..len].
  task automatic do_read(input string tag, input logic [7:0] addr, input logic [3:0] len, input bit toggle);
    int rd0, wr0, d0, cyc;
    logic seen;
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
    beat_q.delete(); last_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len; rdata_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      rdata_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
    end
    seen = done;
    rdata_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rd_en_cycles"}, 32'(rd_cnt - rd0), 32'(len) + 32'd1);
    check_eq({tag, "_wr_en_cycles"}, 32'(wr_cnt - wr0), 32'd0);
    check_eq({tag, "_beats"}, 32'(beat_q.size()), 32'(len) + 32'd1);
    for (int i = 0; i < beat_q.size() && i < 16; i++) begin
      check_eq($sformatf("%s_beat%0d", tag, i), 32'(beat_q[i]), 32'(exp_data[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == int'(len)));
    end
    $display("read  %s addr=%0d len=%0d beats=%0d", tag, addr, len, beat_q.size());
  endtask

  // Write burst from wr_data[0..len]; optional one-cycle valid gap once gap_at beats went in.
  task automatic do_write(input string tag, input logic [7:0] addr, input logic [3:0] len, input int gap_at);
    int rd0, wr0, d0, k, cyc;
    bit gap_done;
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt; k = 0; gap_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 0; cyc < 200 && k <= int'(len); cyc++) begin
      if (k == gap_at && !gap_done && wdata_ready) begin
        wdata_valid = 1'b0;
        gap_done = 1'b1;
      end else begin
        wdata_valid = 1'b1;
        wdata = wr_data[k];
      end
      if (wdata_ready && wdata_valid) k++;
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    check_eq({tag, "_beats_taken"}, 32'(k), 32'(len) + 32'd1);
    check_eq({tag, "_done_after_last"}, 32'(done), 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_wr_en_cycles"}, 32'(wr_cnt - wr0), 32'(len) + 32'd1);
    check_eq({tag, "_rd_en_cycles"}, 32'(rd_cnt - rd0), 32'd0);
    $display("write %s addr=%0d len=%0d beats=%0d", tag, addr, len, k);
  endtask

  // Single request expected to be rejected on range.
  task automatic do_reject(input string tag, input logic [7:0] addr, input logic [3:0] len, input logic wr);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "_err_pulse"}, 32'(err), 32'd1);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    check_eq({tag, "_err_clear"}, 32'(err), 32'd0);
    check_eq({tag, "_no_ram_access"}, 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    $display("rej   %s addr=%0d len=%0d", tag, addr, len);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready",   32'(req_ready),   32'd1);
    check_eq("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check_eq("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check_eq("rst_rdata",       32'(rdata),       32'd0);
    check_eq("rst_rdata_last",  32'(rdata_last),  32'd0);
    check_eq("rst_done_err",    32'({done, err}), 32'd0);
    check_eq("rst_mem_en",      32'({mem_rd_en, mem_wr_en}), 32'd0);
    check_eq("rst_mem_addr",    32'(mem_addr),    32'd0);
    check_eq("rst_mem_wdata",   32'(mem_wdata),   32'd0);
    rst_n = 1'b1;
    $display("reset released");

    exp_data[0] = 8'd5;
    do_read("rd5", 8'd5, 4'd0, 1'b0);

    for (int i = 0; i < 8; i++) exp_data[i] = 8'(120 + i);
    do_read("rd120", 8'd120, 4'd7, 1'b0);
    do_read("rd120_stall", 8'd120, 4'd7, 1'b1);

    wr_data[0] = 8'hAA; wr_data[1] = 8'hBB; wr_data[2] = 8'hCC; wr_data[3] = 8'hDD;
    do_write("wr10", 8'd10, 4'd3, 2);
    check_eq("ram10", 32'(ram[10]), 32'hAA);
    check_eq("ram11", 32'(ram[11]), 32'hBB);
    check_eq("ram12", 32'(ram[12]), 32'hCC);
    check_eq("ram13", 32'(ram[13]), 32'hDD);
    exp_data[0] = 8'hAA; exp_data[1] = 8'hBB; exp_data[2] = 8'hCC; exp_data[3] = 8'hDD;
    do_read("rd10", 8'd10, 4'd3, 1'b0);

    do_reject("rej125", 8'd125, 4'd3, 1'b0);
    do_reject("rej200w", 8'd200, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) exp_data[i] = 8'(124 + i);
    do_read("rd124", 8'd124, 4'd3, 1'b0);

    wr_data[0] = 8'h77;
    do_write("wr127", 8'd127, 4'd0, 99);
    check_eq("ram127", 32'(ram[127]), 32'h77);

    // Reset in the middle of an 8-beat write, while the 3rd beat is offered.
    for (int i = 0; i < 8; i++) wr_data[i] = 8'(8'h50 + i);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd40; req_len = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 50 && k < 2; cyc++) begin
      wdata_valid = 1'b1;
      wdata = wr_data[k];
      if (wdata_ready) k++;
      @(negedge clk);
    end
    wdata_valid = 1'b1;
    wdata = wr_data[2];
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_en",       32'(mem_wr_en),   32'd0);
    check_eq("mid_rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check_eq("mid_rst_req_ready",   32'(req_ready),   32'd1);
    check_eq("mid_rst_mem_addr",    32'(mem_addr),    32'd0);
    check_eq("mid_rst_mem_wdata",   32'(mem_wdata),   32'd0);
    @(negedge clk);
    wdata_valid = 1'b0;
    rst_n = 1'b1;
    $display("reset mid-write after %0d beats", k);
    check_eq("ram40", 32'(ram[40]), 32'h50);
    check_eq("ram41", 32'(ram[41]), 32'h51);
    check_eq("ram42", 32'(ram[42]), 32'd42);
    check_eq("ram47", 32'(ram[47]), 32'd47);
    exp_data[0] = 8'h50; exp_data[1] = 8'h51; exp_data[2] = 8'd42;
    do_read("rd40", 8'd40, 4'd2, 1'b0);

    check_eq("never_rd_and_wr", 32'(both_err), 32'd0);
    check_eq("rd_latency",      32'(lat_err),  32'd0);
    check_eq("stall_stable",    32'(stab_err), 32'd0);
    check_eq("err_pulse_total", 32'(err_cnt),  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
